// File: rtl/divisor_sequencial_pkg.sv
// Shared definitions for the sequential restoring divider: control states and default width.
package divisor_sequencial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    ITER,
    DONE
  } state_t;

  localparam int unsigned N_DEF = 4;

endpackage

// File: rtl/divisor_sequencial_subtrator_comp.sv
// (W)-bit subtractor/comparator: difference a-b and the a>=b flag, shared by CHECK and ITER.
module subtrator_comp #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         ge
);

  assign diff = a - b;
  assign ge   = (a >= b);

endmodule

// File: rtl/divisor_sequencial.sv
// Sequential shift-subtract (restoring) divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
module divisor_sequencial
  import divisor_sequencial_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic           Clk,
  input  logic           Rst_n,
  input  logic           St,
  input  logic [2*N-1:0] Dividendo,
  input  logic [N-1:0]   Divisor,
  output logic [N-1:0]   Quociente,
  output logic [N-1:0]   Resto,
  output logic           V,
  output logic           Done,
  output logic           Idle
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  state_t          state_q, state_d;
  logic [2*N:0]    acc_q, acc_d;
  logic [N-1:0]    div_q, div_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            v_q, v_d;

  logic [2*N:0]    shifted;
  logic [2*N:0]    t;
  logic [N:0]      sub_a;
  logic [N:0]      sub_diff;
  logic            sub_ge;

  assign shifted = acc_q << 1;

  // One comparator serves both states: CHECK compares the unshifted upper half, ITER the shifted one.
  assign sub_a = (state_q == CHECK) ? {1'b0, acc_q[2*N-1:N]} : shifted[2*N:N];

  subtrator_comp #(
    .W (N + 1)
  ) u_sub (
    .a    (sub_a),
    .b    ({1'b0, div_q}),
    .diff (sub_diff),
    .ge   (sub_ge)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    v_d     = v_q;
    t       = shifted;
    case (state_q)
      IDLE: begin
        if (St) begin
          acc_d   = {1'b0, Dividendo};
          div_d   = Divisor;
          v_d     = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (sub_ge || (div_q == '0)) begin
          v_d     = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = '0;
          state_d = ITER;
        end
      end
      ITER: begin
        if (sub_ge) begin
          t[2*N:N] = sub_diff;
          t[0]     = 1'b1;
        end
        acc_d = t;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      v_q     <= v_d;
    end
  end

  assign Quociente = acc_q[N-1:0];
  assign Resto     = acc_q[2*N-1:N];
  assign V         = v_q;
  assign Done      = (state_q == DONE);
  assign Idle      = (state_q == IDLE);

endmodule
